// File: rtl/gray_pkg.sv
// Shared helpers for the parametrised Gray counter: width limits and
// binary <-> Gray conversion over the widest legal counter.
package gray_pkg;

   localparam int unsigned GRAY_MIN_WIDTH = 2;
   localparam int unsigned GRAY_MAX_WIDTH = 32;

   // True when a counter width lies inside the supported range.
   function automatic bit width_ok(input int unsigned width);
      return (width >= GRAY_MIN_WIDTH) && (width <= GRAY_MAX_WIDTH);
   endfunction

   // Binary to Gray: each bit is the XOR of itself and its upper neighbour.
   function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   // Gray to binary: prefix XOR running from the MSB down. Zero-extended
   // upper bits contribute nothing, so narrower counters can use it as is.
   function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] gray);
      logic [GRAY_MAX_WIDTH-1:0] bin;
      bin[GRAY_MAX_WIDTH-1] = gray[GRAY_MAX_WIDTH-1];
      for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/gray_counter_param_step.sv
// Combinational step logic for gray_counter_param: given the current binary
// count, enable and direction, produce the next binary value, its Gray
// encoding and whether this step crosses a wrap point.
module gray_step
   import gray_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] bin_q,
   input  logic             dir,
   input  logic             en,
   output logic [WIDTH-1:0] next_bin,
   output logic [WIDTH-1:0] next_gray,
   output logic             wrap
);

   // Step up or down by one with modular wrap; flag the all-ones/all-zeros crossing.
   always_comb begin
      // NOTE: defaults first so every path assigns every output -- otherwise a latch is inferred.
      next_bin = bin_q;
      wrap     = 1'b0;
      if (en) begin
         if (dir) begin
            next_bin = bin_q + 1'b1;
            wrap     = &bin_q;
         end else begin
            next_bin = bin_q - 1'b1;
            wrap     = ~|bin_q;
         end
      end
   end

   assign next_gray = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(next_bin)));

endmodule

// File: rtl/gray_counter_param.sv
// Parametrised Gray-code counter with count enable, up/down direction,
// synchronous load and a one-cycle wrap pulse. All outputs are registered so
// o_gray can be sampled safely from another clock domain.
// Optional feature: define GRAY_CNT_BIN_OUT_EN to register the binary count
// on o_bin; without it o_bin is a constant zero with no flops behind it.
module gray_counter_param
   import gray_pkg::*;
#(
   parameter int unsigned                WIDTH   = 4,
   parameter logic [GRAY_MAX_WIDTH-1:0]  RST_VAL = '0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic             i_dir,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   output logic [WIDTH-1:0] o_gray,
   output logic [WIDTH-1:0] o_bin,
   output logic             o_wrap
);

   localparam logic [WIDTH-1:0] RST_BIN  = RST_VAL[WIDTH-1:0];
   localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(RST_BIN)));

   if (!width_ok(WIDTH)) begin : g_width_check
      $error("gray_counter_param: WIDTH must lie between GRAY_MIN_WIDTH and GRAY_MAX_WIDTH");
   end

   logic [WIDTH-1:0] bin_q;
   logic [WIDTH-1:0] step_bin;
   logic [WIDTH-1:0] step_gray;
   logic             step_wrap;
   logic [WIDTH-1:0] load_gray;
   logic [WIDTH-1:0] next_bin;
   logic [WIDTH-1:0] next_gray;
   logic             next_wrap;

   gray_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .bin_q     (bin_q),
      .dir       (i_dir),
      .en        (i_en),
      .next_bin  (step_bin),
      .next_gray (step_gray),
      .wrap      (step_wrap)
   );

   // Load has priority over counting; a load never reports a wrap.
   assign load_gray = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(i_load_val)));
   assign next_bin  = i_load ? i_load_val : step_bin;
   assign next_gray = i_load ? load_gray  : step_gray;
   assign next_wrap = i_load ? 1'b0       : step_wrap;

   // Count state and registered Gray/wrap outputs, updated together.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         bin_q  <= RST_BIN;
         o_gray <= RST_GRAY;
         o_wrap <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values, whatever the statement order.
         bin_q  <= next_bin;
         o_gray <= next_gray;
         o_wrap <= next_wrap;
      end
   end

`ifdef GRAY_CNT_BIN_OUT_EN
   // Registered binary copy of the count, aligned with o_gray.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_bin <= RST_BIN;
      end else begin
         o_bin <= next_bin;
      end
   end
`else
   assign o_bin = '0;
`endif

endmodule

// File: tb/tb_gray_counter_param.sv
// Self-checking bench for gray_counter_param (WIDTH = 4, RST_VAL = 0).
// Table-driven directed vectors, a mid-count asynchronous reset sequence and
// a random phase against an integer reference model. Expected results are
// queued when stimulus is driven and compared when the outputs appear.
module tb_gray_counter_param;

   localparam int W = 4;

   logic         clk;
   logic         rst_n;
   logic         en;
   logic         dir;
   logic         load;
   logic [W-1:0] load_val;
   logic [W-1:0] gray;
   logic [W-1:0] bin;
   logic         wrap;

   int n_vec  = 0;
   int n_miss = 0;

   typedef struct {
      bit         ld;
      logic [3:0] val;
      bit         en;
      bit         dir;
      logic [3:0] gray;
      bit         wrap;
   } vec_t;

   typedef struct {
      logic [3:0] gray;
      bit         wrap;
      logic [3:0] bin;
      bit         onebit;
      string      name;
   } exp_t;

   vec_t       tbl[$];
   exp_t       exp_q[$];
   int         m_bin;
   logic [3:0] prev_gray;

   gray_counter_param #(
      .WIDTH   (W),
      .RST_VAL (32'd0)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_en       (en),
      .i_dir      (dir),
      .i_load     (load),
      .i_load_val (load_val),
      .o_gray     (gray),
      .o_bin      (bin),
      .o_wrap     (wrap)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] tb_gray2bin(input logic [3:0] g);
      logic [3:0] b;
      b[3] = g[3];
      b[2] = b[3] ^ g[2];
      b[1] = b[2] ^ g[1];
      b[0] = b[1] ^ g[0];
      return b;
   endfunction

   // Integer reference model of one clock edge.
   task automatic model_step(input bit ld, input logic [3:0] val, input bit e, input bit d,
                             output logic [3:0] g, output bit w);
      w = 1'b0;
      if (ld) begin
         m_bin = int'(val);
      end else if (e && d) begin
         w     = (m_bin == 15);
         m_bin = (m_bin + 1) % 16;
      end else if (e) begin
         w     = (m_bin == 0);
         m_bin = (m_bin + 15) % 16;
      end
      g = 4'(m_bin ^ (m_bin >> 1));
   endtask

   task automatic check_bin(input string name, input logic [3:0] exp_bin);
`ifdef GRAY_CNT_BIN_OUT_EN
      check({name, ".bin"}, 32'(bin), 32'(exp_bin));
      check({name, ".bin_dec"}, 32'(bin), 32'(tb_gray2bin(gray)));
`else
      check({name, ".bin_zero"}, 32'(bin), 32'(exp_bin & 4'h0));
`endif
   endtask

   // Pop the oldest expectation and compare it with the outputs now visible.
   task automatic sample();
      exp_t e;
      if (exp_q.size() == 0) begin
         check("scoreboard_empty", 32'd1, 32'd0);
         return;
      end
      e = exp_q.pop_front();
      check({e.name, ".gray"}, 32'(gray), 32'(e.gray));
      check({e.name, ".wrap"}, 32'(wrap), 32'(e.wrap));
      check_bin(e.name, e.bin);
      if (e.onebit) check({e.name, ".onebit"}, 32'($countones(gray ^ prev_gray)), 32'd1);
      prev_gray = gray;
   endtask

   // Drive one cycle of stimulus, queue the expectation, sample after the edge.
   task automatic run_cycle(input bit ld, input logic [3:0] val, input bit e, input bit d,
                            input bit use_tbl, input logic [3:0] t_gray, input bit t_wrap,
                            input string name);
      exp_t       x;
      logic [3:0] mg;
      bit         mw;
      load     = ld;
      load_val = val;
      en       = e;
      dir      = d;
      model_step(ld, val, e, d, mg, mw);
      x.gray   = use_tbl ? t_gray : mg;
      x.wrap   = use_tbl ? t_wrap : mw;
      x.bin    = 4'(m_bin);
      x.onebit = e && !ld;
      x.name   = name;
      exp_q.push_back(x);
      @(posedge clk);
      #1;
      sample();
   endtask

   task automatic add(input bit ld, input logic [3:0] val, input bit e, input bit d,
                      input logic [3:0] g, input bit w);
      vec_t v;
      v.ld = ld; v.val = val; v.en = e; v.dir = d; v.gray = g; v.wrap = w;
      tbl.push_back(v);
   endtask

   initial begin
      logic [3:0] up_seq [16];
      up_seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};

      // Idle with enable low.
      for (int i = 0; i < 5; i++) add(1'b0, 4'h0, 1'b0, 1'b1, 4'b0000, 1'b0);
      // Full up lap, wrapping back to zero on the last step.
      for (int i = 0; i < 16; i++) add(1'b0, 4'h0, 1'b1, 1'b1, up_seq[i], i == 15);
      // Down through the zero wrap point.
      add(1'b0, 4'h0, 1'b1, 1'b0, 4'b1000, 1'b1);
      add(1'b0, 4'h0, 1'b1, 1'b0, 4'b1001, 1'b0);
      // Load beats enable, then one up step.
      add(1'b1, 4'd5, 1'b1, 1'b1, 4'b0111, 1'b0);
      add(1'b0, 4'h0, 1'b1, 1'b1, 4'b0101, 1'b0);
      // Up to binary 10.
      add(1'b0, 4'h0, 1'b1, 1'b1, 4'b0100, 1'b0);
      add(1'b0, 4'h0, 1'b1, 1'b1, 4'b1100, 1'b0);
      add(1'b0, 4'h0, 1'b1, 1'b1, 4'b1101, 1'b0);
      add(1'b0, 4'h0, 1'b1, 1'b1, 4'b1111, 1'b0);

      rst_n    = 1'b0;
      en       = 1'b0;
      dir      = 1'b1;
      load     = 1'b0;
      load_val = 4'h0;
      m_bin    = 0;

      @(posedge clk);
      #1;
      check("reset.gray", 32'(gray), 32'd0);
      check("reset.wrap", 32'(wrap), 32'd0);
      check_bin("reset", 4'd0);
      prev_gray = 4'b0000;
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         run_cycle(tbl[i].ld, tbl[i].val, tbl[i].en, tbl[i].dir,
                   1'b1, tbl[i].gray, tbl[i].wrap, $sformatf("vec%0d", i));
      end

      // Reset between edges clears outputs without waiting for a clock.
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst.gray", 32'(gray), 32'd0);
      check("async_rst.wrap", 32'(wrap), 32'd0);
      check_bin("async_rst", 4'd0);
      en  = 1'b1;
      dir = 1'b1;
      @(posedge clk);
      #1;
      check("rst_hold.gray", 32'(gray), 32'd0);
      m_bin     = 0;
      prev_gray = 4'b0000;
      rst_n     = 1'b1;
      run_cycle(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'b0001, 1'b0, "post_rst_up1");
      run_cycle(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'b0011, 1'b0, "post_rst_up2");
      // Direction reversal with enable high: no skipped or repeated value.
      run_cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'b0001, 1'b0, "reverse_dn");
      run_cycle(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'b0011, 1'b0, "reverse_up");

      // Random sequences checked against the reference model.
      for (int i = 0; i < 1000; i++) begin
         bit         r_ld;
         bit         r_en;
         bit         r_dir;
         logic [3:0] r_val;
         r_ld  = ($urandom_range(7) == 0);
         r_en  = ($urandom_range(3) != 0);
         r_dir = 1'($urandom_range(1));
         r_val = 4'($urandom_range(15));
         run_cycle(r_ld, r_val, r_en, r_dir, 1'b0, 4'h0, 1'b0, $sformatf("rand%0d", i));
      end

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
